// File: rtl/byte_fetch_seq_if.sv
// Bus bundle between the control FSM / byte memory side and byte_fetch_seq.
// master drives requests and memory data; slave is the fetch sequencer.
interface byte_fetch_seq_if #(
    parameter int ADDR_W = 8,
    parameter int NBYTES = 4
);
    logic                start;
    logic [ADDR_W-1:0]   base;
    logic                abort;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rdata;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic [8*NBYTES-1:0] instr;

    modport master (
        output start, base, abort, mem_rdata, mem_ready,
        input  mem_rd, mem_addr, busy, done, instr
    );

    modport slave (
        input  start, base, abort, mem_rdata, mem_ready,
        output mem_rd, mem_addr, busy, done, instr
    );
endinterface

// File: rtl/byte_fetch_seq.sv
// Multi-cycle byte-serial word fetcher: reads NBYTES bytes from an 8-bit memory
// port and publishes the assembled word on instr in one atomic update.
module byte_fetch_seq #(
    parameter int ADDR_W = 8,
    parameter int NBYTES = 4,
    parameter int LITTLE = 1
) (
    input logic             clk,
    input logic             rst,
    byte_fetch_seq_if.slave bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    generate
        if (NBYTES < 1 || NBYTES > 8) begin : g_bad_nbytes
            $error("byte_fetch_seq: NBYTES must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_reg;
    logic [W-1:0]      shadow;
    logic [W-1:0]      instr_reg;
    logic [IDX_W-1:0]  lane;
    logic [W-1:0]      merged;

    // Shadow with the incoming byte dropped into its lane; used both for the
    // running capture and for the final publish on the completing edge.
    // NOTE: every combinational output gets a default before any conditional
    // write, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane   = (LITTLE != 0) ? idx : (LAST_IDX - idx);
        merged = shadow;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane == IDX_W'(i)) begin
                merged[i*8 +: 8] = bus.mem_rdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            addr_reg  <= '0;
            shadow    <= '0;
            instr_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= READ;
                        addr_reg <= bus.base;
                        idx      <= '0;
                    end
                end
                READ: begin
                    // Abort wins over a coincident byte; that byte is dropped.
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.mem_ready) begin
                        shadow   <= merged;
                        addr_reg <= addr_reg + ADDR_W'(1);
                        if (idx == LAST_IDX) begin
                            instr_reg <= merged;
                            state     <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state    <= READ;
                        addr_reg <= bus.base;
                        idx      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd   = (state == READ);
    assign bus.busy     = (state == READ);
    assign bus.done     = (state == DONE);
    assign bus.mem_addr = addr_reg;
    assign bus.instr    = instr_reg;

endmodule

// File: tb/tb_byte_fetch_seq.sv
// Randomised scoreboard bench: a little- and a big-endian instance share one
// stimulus stream; a negedge monitor checks them against a word-level model.
module tb_byte_fetch_seq;
    localparam int ADDR_W = 8;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] base      = 8'h00;
    logic [7:0] mem [256];

    byte_fetch_seq_if #(.ADDR_W(ADDR_W), .NBYTES(NBYTES)) bus_l ();
    byte_fetch_seq_if #(.ADDR_W(ADDR_W), .NBYTES(NBYTES)) bus_b ();

    assign bus_l.start     = start;
    assign bus_l.base      = base;
    assign bus_l.abort     = abort;
    assign bus_l.mem_ready = mem_ready;
    assign bus_l.mem_rdata = mem[bus_l.mem_addr];
    assign bus_b.start     = start;
    assign bus_b.base      = base;
    assign bus_b.abort     = abort;
    assign bus_b.mem_ready = mem_ready;
    assign bus_b.mem_rdata = mem[bus_b.mem_addr];

    byte_fetch_seq #(.ADDR_W(ADDR_W), .NBYTES(NBYTES), .LITTLE(1)) dut_l (
        .clk(clk), .rst(rst), .bus(bus_l)
    );
    byte_fetch_seq #(.ADDR_W(ADDR_W), .NBYTES(NBYTES), .LITTLE(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] b;
    } exp_t;

    exp_t       sb [$];
    exp_t       last      = '0;
    logic       exp_busy  = 1'b0;
    logic       exp_done  = 1'b0;
    logic [7:0] exp_addr  = 8'h00;
    int         n_checks  = 0;
    int         n_errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word model: byte k of the fetch comes from base+k (mod 256).
    function automatic exp_t model(input logic [7:0] b);
        exp_t       e;
        logic [7:0] a;
        e = '0;
        for (int k = 0; k < NBYTES; k++) begin
            a = b + 8'(k);
            e.l[8*k +: 8]              = mem[a];
            e.b[8*(NBYTES-1-k) +: 8]   = mem[a];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("ctl_l", {bus_l.busy, bus_l.mem_rd, bus_l.done}, {exp_busy, exp_busy, exp_done});
            check("ctl_b", {bus_b.busy, bus_b.mem_rd, bus_b.done}, {exp_busy, exp_busy, exp_done});
            if (exp_busy) begin
                check("addr_l", bus_l.mem_addr, exp_addr);
                check("addr_b", bus_b.mem_addr, exp_addr);
            end
            if (bus_l.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending fetch at %0t", $time);
                end else begin
                    last = sb.pop_front();
                end
            end
            check("instr_l", bus_l.instr, last.l);
            check("instr_b", bus_b.instr, last.b);
        end
    end

    task automatic idle(input bit rand_abort);
        start     = 1'b0;
        abort     = rand_abort ? 1'($urandom_range(1)) : 1'b0;
        mem_ready = 1'($urandom_range(1));
        @(posedge clk); #1;
        abort     = 1'b0;
        mem_ready = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Issues one fetch; entered and left just after a rising edge.
    task automatic fetch(input logic [7:0] b, input int abort_at, input bit abort_rdy,
                         input int rst_at, input int wait_pct, input int wait_k, input int wait_n);
        int nw;
        int k;
        start = 1'b1;
        base  = b;
        abort = 1'($urandom_range(1));
        mem_ready = 1'b0;
        if (abort_at < 0 && rst_at < 0) sb.push_back(model(b));
        @(posedge clk); #1;
        start    = 1'b0;
        abort    = 1'b0;
        exp_done = 1'b0;
        exp_busy = 1'b1;
        exp_addr = b;
        k = 0;
        while (k < NBYTES) begin
            if (k == rst_at) begin
                @(negedge clk); #2;
                rst = 1'b1;
                #1;
                check("rst_async_l", {bus_l.busy, bus_l.mem_rd, bus_l.done, bus_l.mem_addr, bus_l.instr}, '0);
                check("rst_async_b", {bus_b.busy, bus_b.mem_rd, bus_b.done, bus_b.mem_addr, bus_b.instr}, '0);
                exp_busy = 1'b0;
                exp_done = 1'b0;
                last     = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            nw = (k == wait_k) ? wait_n : 0;
            if (wait_pct > 0 && $urandom_range(99) < wait_pct) nw = $urandom_range(1, 3);
            repeat (nw) begin
                mem_ready = 1'b0;
                start     = 1'($urandom_range(3) == 0);
                base      = 8'($urandom);
                @(posedge clk); #1;
            end
            if (k == abort_at) begin
                abort     = 1'b1;
                mem_ready = abort_rdy;
                @(posedge clk); #1;
                abort     = 1'b0;
                mem_ready = 1'b0;
                start     = 1'b0;
                exp_busy  = 1'b0;
                return;
            end
            mem_ready = 1'b1;
            start     = 1'($urandom_range(3) == 0);
            @(posedge clk); #1;
            mem_ready = 1'b0;
            start     = 1'b0;
            k++;
            exp_addr = exp_addr + 8'd1;
        end
        exp_busy = 1'b0;
        exp_done = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h11;
        mem[8'h11] = 8'h22;
        mem[8'h12] = 8'h33;
        mem[8'h13] = 8'h44;

        #1;
        check("reset_l", {bus_l.busy, bus_l.mem_rd, bus_l.done, bus_l.mem_addr, bus_l.instr}, '0);
        check("reset_b", {bus_b.busy, bus_b.mem_rd, bus_b.done, bus_b.mem_addr, bus_b.instr}, '0);
        #11 rst = 1'b0;
        @(posedge clk); #1;
        repeat (10) idle(1'b0);
        check("idle_quiet", {bus_l.mem_rd, bus_l.done}, 2'b00);

        // Basic little-endian fetch, zero wait states.
        fetch(8'h10, -1, 1'b0, -1, 0, -1, 0);
        @(negedge clk);
        check("basic_done", bus_l.done, 1'b1);
        check("basic_instr", bus_l.instr, 32'h44332211);
        @(posedge clk); #1;
        exp_done = 1'b0;
        idle(1'b0);

        // Two wait states before byte 1; big-endian lane order.
        fetch(8'h10, -1, 1'b0, -1, 0, 1, 2);
        @(negedge clk);
        check("wait_done", bus_b.done, 1'b1);
        check("wait_instr_b", bus_b.instr, 32'h11223344);
        @(posedge clk); #1;
        exp_done = 1'b0;

        // Address wrap, then back-to-back fetch straight out of DONE.
        fetch(8'hFE, -1, 1'b0, -1, 0, -1, 0);
        fetch(8'h40, -1, 1'b0, -1, 0, -1, 0);
        idle(1'b0);

        // Aborts: after two bytes, and coincident with the final byte.
        fetch(8'h10, -1, 1'b0, -1, 0, -1, 0);
        idle(1'b0);
        fetch(8'h50, 2, 1'b0, -1, 0, -1, 0);
        idle(1'b0);
        check("abort2_instr", bus_l.instr, 32'h44332211);
        fetch(8'h60, 3, 1'b1, -1, 0, -1, 0);
        idle(1'b0);
        check("abort_last_instr", bus_l.instr, 32'h44332211);

        // Asynchronous reset with two bytes captured, then a clean fetch.
        fetch(8'h70, -1, 1'b0, 2, 0, -1, 0);
        idle(1'b0);
        check("post_rst_instr", bus_l.instr, 32'h0);
        fetch(8'h20, -1, 1'b0, -1, 0, -1, 0);
        idle(1'b0);

        // Random traffic: bases, wait states, aborts, gaps and back-to-back.
        repeat (60) begin
            int ab;
            ab = ($urandom_range(7) == 0) ? int'($urandom_range(NBYTES - 1)) : -1;
            fetch(8'($urandom), ab, 1'($urandom_range(1)), -1, 30, -1, 0);
            repeat ($urandom_range(2)) idle(1'b1);
        end
        idle(1'b0);
        idle(1'b0);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
